// File: rtl/data_memory_pipelined.sv
// Byte-addressable big-endian data memory for the MEM stage: valid/ready request,
// single-cycle response pulse, configurable read latency and optional alignment check.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | nothing outstanding, ready for a request
// S_WAIT | load accepted, latency counter running, not ready
// S_RESP | response pulse on rsp_*, ready for the next request
module data_memory_pipelined #(
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1,
    parameter bit ALIGN_CHECK  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_se,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_error
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]  r_lat_cnt;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [7:0]  r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [ADDR_WIDTH-1:0] w_addr2;
    logic [ADDR_WIDTH-1:0] w_addr3;
    logic [7:0]            w_byte0;
    logic [7:0]            w_byte1;
    logic [7:0]            w_byte2;
    logic [7:0]            w_byte3;
    logic                  w_ready;
    logic                  w_misaligned;
    logic                  w_accept;
    logic                  w_store_we;
    logic                  w_one_cycle;
    logic [31:0]           w_load_data;

    // Byte lanes wrap modulo the memory depth.
    assign w_addr1 = i_req_addr + ADDR_WIDTH'(1);
    assign w_addr2 = i_req_addr + ADDR_WIDTH'(2);
    assign w_addr3 = i_req_addr + ADDR_WIDTH'(3);

    assign w_byte0 = r_mem[i_req_addr];
    assign w_byte1 = r_mem[w_addr1];
    assign w_byte2 = r_mem[w_addr2];
    assign w_byte3 = r_mem[w_addr3];

    assign w_misaligned = ALIGN_CHECK &&
                          (((i_req_size == 2'b01) && i_req_addr[0]) ||
                           (i_req_size[1] && (i_req_addr[1:0] != 2'b00)));

    assign w_ready     = (r_state != S_WAIT);
    assign o_req_ready = w_ready;
    assign w_accept    = i_req_valid && w_ready && !i_reset;
    assign w_store_we  = w_accept && i_req_write && !w_misaligned;
    assign w_one_cycle = i_req_write || w_misaligned || (READ_LATENCY == 1);

    always_comb begin
        w_load_data = {w_byte0, w_byte1, w_byte2, w_byte3};
        case (i_req_size)
            2'b00:   w_load_data = {{24{i_req_se & w_byte0[7]}}, w_byte0};
            2'b01:   w_load_data = {{16{i_req_se & w_byte0[7]}}, w_byte0, w_byte1};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_rsp_valid  = 1'b0;
        o_rsp_rdata  = 32'd0;
        o_rsp_error  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_one_cycle ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == LAST_CNT) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = r_rsp_data;
                o_rsp_error = r_rsp_err;
                if (w_accept) begin
                    w_state_next = w_one_cycle ? S_RESP : S_WAIT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counts edges spent since a multi-cycle load was accepted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lat_cnt <= 3'd0;
        end else if (w_accept && !w_one_cycle) begin
            r_lat_cnt <= 3'd1;
        end else if (r_state == S_WAIT) begin
            r_lat_cnt <= (r_lat_cnt == LAST_CNT) ? 3'd0 : r_lat_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_data <= (i_req_write || w_misaligned) ? 32'd0 : w_load_data;
            r_rsp_err  <= w_misaligned;
        end
    end

    // Array is never reset; a store commits at its accept edge.
    always_ff @(posedge i_clk) begin
        if (w_store_we) begin
            case (i_req_size)
                2'b00: begin
                    r_mem[i_req_addr] <= i_req_wdata[7:0];
                end
                2'b01: begin
                    r_mem[i_req_addr] <= i_req_wdata[15:8];
                    r_mem[w_addr1]    <= i_req_wdata[7:0];
                end
                default: begin
                    r_mem[i_req_addr] <= i_req_wdata[31:24];
                    r_mem[w_addr1]    <= i_req_wdata[23:16];
                    r_mem[w_addr2]    <= i_req_wdata[15:8];
                    r_mem[w_addr3]    <= i_req_wdata[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: three instances (latency 1/3/4, alignment check on/on/off)
// driven by directed and random request streams against a byte-array reference model.
module tb_data_memory_pipelined;

    typedef struct packed {
        logic        gap;
        logic        w;
        logic [1:0]  sz;
        logic        se;
        logic [8:0]  a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_d;
        logic        exp_e;
    } req_t;

    logic        clk;
    logic        rst  [3];
    logic        vld  [3];
    logic        wr   [3];
    logic [1:0]  sz   [3];
    logic        se   [3];
    logic [8:0]  addr [3];
    logic [31:0] wd   [3];
    logic        rdy  [3];
    logic        rv   [3];
    logic [31:0] rd   [3];
    logic        re   [3];

    logic [7:0] mm [3][512];
    req_t       q[$];
    int         n_cmp;
    int         n_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_pipelined #(.ADDR_WIDTH(9), .READ_LATENCY(1), .ALIGN_CHECK(1'b1)) dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_req_valid(vld[0]), .o_req_ready(rdy[0]),
        .i_req_write(wr[0]), .i_req_size(sz[0]), .i_req_se(se[0]), .i_req_addr(addr[0]),
        .i_req_wdata(wd[0]), .o_rsp_valid(rv[0]), .o_rsp_rdata(rd[0]), .o_rsp_error(re[0]));

    data_memory_pipelined #(.ADDR_WIDTH(9), .READ_LATENCY(3), .ALIGN_CHECK(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_req_valid(vld[1]), .o_req_ready(rdy[1]),
        .i_req_write(wr[1]), .i_req_size(sz[1]), .i_req_se(se[1]), .i_req_addr(addr[1]),
        .i_req_wdata(wd[1]), .o_rsp_valid(rv[1]), .o_rsp_rdata(rd[1]), .o_rsp_error(re[1]));

    data_memory_pipelined #(.ADDR_WIDTH(9), .READ_LATENCY(4), .ALIGN_CHECK(1'b0)) dut2 (
        .i_clk(clk), .i_reset(rst[2]), .i_req_valid(vld[2]), .o_req_ready(rdy[2]),
        .i_req_write(wr[2]), .i_req_size(sz[2]), .i_req_se(se[2]), .i_req_addr(addr[2]),
        .i_req_wdata(wd[2]), .o_rsp_valid(rv[2]), .o_rsp_rdata(rd[2]), .o_rsp_error(re[2]));

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic bit misal(int d, logic [1:0] s, logic [8:0] a);
        if (d == 2) return 1'b0;
        if (s == 2'b01) return (int'(a) % 2) != 0;
        if (s >= 2'b10) return (int'(a) % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(int d, logic [1:0] s, logic sev, logic [8:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(s);
        for (int k = 0; k < n; k++) v = v * 256 + 32'(mm[d][(int'(a) + k) % 512]);
        if (sev && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic model_store(int d, logic [1:0] s, logic [8:0] a, logic [31:0] wdv);
        int n;
        n = nbytes(s);
        for (int k = 0; k < n; k++) mm[d][(int'(a) + k) % 512] = 8'(wdv >> (8 * (n - 1 - k)));
    endtask

    task automatic push(bit gap, bit w, logic [1:0] s, bit sev, logic [8:0] a, logic [31:0] wdv,
                        bit chk, logic [31:0] ex, bit exe);
        req_t r;
        r.gap = gap; r.w = w; r.sz = s; r.se = sev; r.a = a; r.wd = wdv;
        r.chk = chk; r.exp_d = ex; r.exp_e = exe;
        q.push_back(r);
    endtask

    // Plays the queue into instance d; starts and ends just after a falling edge with the DUT idle.
    task automatic run_seq(int d);
        int          cyc;
        bit          pend;
        int          due;
        logic [31:0] e_d;
        logic        e_e;
        bit          e_chk;
        logic [31:0] e_x;
        logic        e_xe;
        bit          have;
        req_t        cur;
        bit          e_rdy;
        int          n_acc;
        int          n_rsp;
        int          leff;
        cyc = 0; pend = 0; due = 0; e_d = 0; e_e = 0; e_chk = 0; e_x = 0; e_xe = 0;
        have = 0; cur = '0; n_acc = 0; n_rsp = 0;
        while ((q.size() > 0 || have || pend) && cyc < 4000) begin
            e_rdy = !(pend && due > cyc);
            n_cmp++;
            if (rdy[d] !== e_rdy) begin
                n_mis++;
                $display("FAIL ready d%0d cyc%0d: got %b want %b", d, cyc, rdy[d], e_rdy);
            end
            if (rv[d] === 1'b1) n_rsp++;
            if (pend && due == cyc) begin
                n_cmp++;
                if (rv[d] !== 1'b1 || rd[d] !== e_d || re[d] !== e_e) begin
                    n_mis++;
                    $display("FAIL response d%0d cyc%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                             d, cyc, rv[d], rd[d], re[d], e_d, e_e);
                end
                if (e_chk) begin
                    n_cmp++;
                    if (rd[d] !== e_x || re[d] !== e_xe) begin
                        n_mis++;
                        $display("FAIL directed d%0d cyc%0d: got d=%h e=%b want d=%h e=%b",
                                 d, cyc, rd[d], re[d], e_x, e_xe);
                    end
                end
                pend = 0;
            end else begin
                n_cmp++;
                if (rv[d] !== 1'b0 || rd[d] !== 32'd0 || re[d] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL quiet d%0d cyc%0d: got v=%b d=%h e=%b want all zero",
                             d, cyc, rv[d], rd[d], re[d]);
                end
            end
            if (!have && q.size() > 0) begin
                cur = q.pop_front();
                have = 1;
            end
            vld[d] = 1'b0;
            if (have && cur.gap) begin
                have = 0;
                addr[d] = 9'($urandom);
            end else if (have) begin
                vld[d] = 1'b1; wr[d] = cur.w; sz[d] = cur.sz; se[d] = cur.se;
                addr[d] = cur.a; wd[d] = cur.wd;
                if (e_rdy) begin
                    have = 0;
                    n_acc++;
                    leff = (cur.w || misal(d, cur.sz, cur.a)) ? 1 : lat_of(d);
                    if (misal(d, cur.sz, cur.a)) begin
                        e_d = 0; e_e = 1;
                    end else if (cur.w) begin
                        model_store(d, cur.sz, cur.a, cur.wd);
                        e_d = 0; e_e = 0;
                    end else begin
                        e_d = model_load(d, cur.sz, cur.se, cur.a); e_e = 0;
                    end
                    e_chk = cur.chk; e_x = cur.exp_d; e_xe = cur.exp_e;
                    pend = 1;
                    due = cyc + leff;
                end
            end
            @(negedge clk);
            cyc++;
        end
        vld[d] = 1'b0;
        if (cyc >= 4000) begin
            n_cmp++; n_mis++;
            $display("FAIL timeout d%0d: got %0d cycles want under 4000", d, cyc);
            q.delete();
        end
        n_cmp++;
        if (n_rsp != n_acc) begin
            n_mis++;
            $display("FAIL rsp_count d%0d: got %0d responses want %0d", d, n_rsp, n_acc);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; vld[d] = 1'b0; wr[d] = 1'b0; sz[d] = 2'b00; se[d] = 1'b0;
            addr[d] = 9'd0; wd[d] = 32'd0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (rdy[d] !== 1'b1 || rv[d] !== 1'b0 || rd[d] !== 32'd0 || re[d] !== 1'b0) begin
                n_mis++;
                $display("FAIL reset d%0d: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                         d, rdy[d], rv[d], rd[d], re[d]);
            end
            rst[d] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 128; i++) push(0, 1, 2'b10, 0, 9'(i * 4), $urandom, 0, 0, 0);
            run_seq(d);
        end
    endtask

    task automatic test_word_store_byte_loads();
        push(0, 1, 2'b10, 0, 9'h010, 32'h12345678, 1, 32'h0, 0);
        push(0, 0, 2'b00, 0, 9'h010, 0, 1, 32'h12, 0);
        push(0, 0, 2'b00, 0, 9'h011, 0, 1, 32'h34, 0);
        push(0, 0, 2'b00, 0, 9'h012, 0, 1, 32'h56, 0);
        push(0, 0, 2'b00, 0, 9'h013, 0, 1, 32'h78, 0);
        run_seq(0);
    endtask

    task automatic test_sign_ext();
        push(0, 1, 2'b01, 0, 9'h020, 32'h000080F0, 1, 32'h0, 0);
        push(0, 0, 2'b01, 1, 9'h020, 0, 1, 32'hFFFF80F0, 0);
        push(0, 0, 2'b01, 0, 9'h020, 0, 1, 32'h000080F0, 0);
        push(0, 0, 2'b00, 1, 9'h021, 0, 1, 32'hFFFFFFF0, 0);
        push(0, 0, 2'b00, 1, 9'h020, 0, 1, 32'hFFFFFF80, 0);
        push(0, 0, 2'b11, 1, 9'h020, 0, 0, 0, 0);
        run_seq(0);
    endtask

    task automatic test_misalign();
        push(0, 1, 2'b10, 0, 9'h030, 32'h01020304, 1, 32'h0, 0);
        push(0, 1, 2'b10, 0, 9'h031, 32'hDEADBEEF, 1, 32'h0, 1);
        push(0, 0, 2'b10, 0, 9'h030, 0, 1, 32'h01020304, 0);
        push(0, 0, 2'b01, 0, 9'h033, 0, 1, 32'h0, 1);
        push(0, 1, 2'b01, 0, 9'h031, 32'h0000FFFF, 1, 32'h0, 1);
        push(0, 0, 2'b10, 0, 9'h030, 0, 1, 32'h01020304, 0);
        run_seq(0);
    endtask

    task automatic test_latency_handshake();
        logic [1:0] s;
        for (int i = 0; i < 10; i++) begin
            s = 2'($urandom_range(0, 3));
            push(0, 0, s, 1'($urandom), 9'($urandom) & ~9'(nbytes(s) - 1), 0, 0, 0, 0);
        end
        run_seq(1);
    endtask

    task automatic test_reset_mid_read();
        push(0, 1, 2'b10, 0, 9'h040, 32'h5A6B7C8D, 1, 32'h0, 0);
        run_seq(2);
        wr[2] = 1'b0; sz[2] = 2'b10; se[2] = 1'b0; addr[2] = 9'h040; vld[2] = 1'b1;
        n_cmp++;
        if (rdy[2] !== 1'b1) begin
            n_mis++;
            $display("FAIL midrst_accept: got rdy=%b want 1", rdy[2]);
        end
        @(negedge clk);
        vld[2] = 1'b0;
        n_cmp++;
        if (rdy[2] !== 1'b0 || rv[2] !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_wait: got rdy=%b v=%b want 0 0", rdy[2], rv[2]);
        end
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        n_cmp++;
        if (rdy[2] !== 1'b1 || rv[2] !== 1'b0 || rd[2] !== 32'd0 || re[2] !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_after: got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                     rdy[2], rv[2], rd[2], re[2]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rv[2] !== 1'b0 || rdy[2] !== 1'b1) begin
                n_mis++;
                $display("FAIL midrst_no_pulse cyc%0d: got v=%b rdy=%b want 0 1", i, rv[2], rdy[2]);
            end
        end
        push(0, 0, 2'b10, 0, 9'h040, 0, 1, 32'h5A6B7C8D, 0);
        run_seq(2);
    endtask

    task automatic test_wrap();
        push(0, 1, 2'b10, 0, 9'h1FE, 32'hA1B2C3D4, 1, 32'h0, 0);
        push(0, 0, 2'b00, 0, 9'h1FE, 0, 1, 32'hA1, 0);
        push(0, 0, 2'b00, 0, 9'h1FF, 0, 1, 32'hB2, 0);
        push(0, 0, 2'b00, 0, 9'h000, 0, 1, 32'hC3, 0);
        push(0, 0, 2'b00, 0, 9'h001, 0, 1, 32'hD4, 0);
        push(0, 0, 2'b10, 0, 9'h1FE, 0, 1, 32'hA1B2C3D4, 0);
        push(0, 0, 2'b01, 1, 9'h1FF, 0, 1, 32'hFFFFB2C3, 0);
        run_seq(2);
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 200; i++) begin
                push($urandom_range(0, 4) == 0, 1'($urandom), 2'($urandom), 1'($urandom),
                     9'($urandom), $urandom, 0, 0, 0);
            end
            run_seq(d);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_fill();
        test_word_store_byte_loads();
        test_sign_ext();
        test_misalign();
        test_latency_handshake();
        test_reset_mid_read();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time %0t want completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_memory_pipelined.md
# data_memory_pipelined

Synchronous, byte-addressable, big-endian data memory for the pipeline's MEM stage, replacing the level-sensitive data memory. Supports byte, halfword and word accesses with optional sign extension. Uses a valid/ready request port and a one-cycle response pulse, with parametrised depth and read latency and optional misalignment checking. One request is outstanding at a time.

## Interface
- ADDR_WIDTH, 9, byte-address width; depth = 2^ADDR_WIDTH bytes (default 512)
- READ_LATENCY, 1, cycles from request acceptance to read response; legal 1..4
- ALIGN_CHECK, 1, 1 = misaligned halfword/word accesses are rejected with error; 0 = allowed, addresses wrap
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10/11 word
- req_se  input  1  sign-extend byte/halfword loads
- req_addr  input  ADDR_WIDTH  byte address of the most-significant byte
- req_wdata  input  32  store data, right-justified (byte = [7:0], half = [15:0])
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_error  output  1  misaligned access; valid only with rsp_valid

## Operation
- Storage: 2^ADDR_WIDTH x 8-bit array. Big-endian: Mem[A] holds the MSB of a multi-byte access, and Mem[A+1..A+3] hold the following bytes.
- Byte addresses A+k are computed modulo 2^ADDR_WIDTH, so wrap-around is defined.
- Reset does not clear the array.
- Accept: a request is accepted at a rising edge where req_valid && req_ready.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; a latency counter runs.
  - RESP: rsp_valid=1 and req_ready=1.
- Transitions:
  - IDLE→RESP on accepting a store, an error, or a load when READ_LATENCY=1.
  - IDLE→WAIT on accepting a load when READ_LATENCY>1.
  - WAIT→RESP when the counter reaches READ_LATENCY-1.
  - RESP→RESP if a new request is accepted and it responds in one cycle.
  - RESP→WAIT if a new load is accepted and READ_LATENCY>1.
  - RESP→IDLE otherwise.
- Misaligned (ALIGN_CHECK=1): half with addr[0]=1, or word with addr[1:0]≠0.
  - Memory is unchanged.
  - Response after 1 cycle with rsp_error=1 and rsp_rdata=0.
  - Applies to both loads and stores.
- Store: bytes are written at the accept edge.
  - size 00 writes wdata[7:0].
  - size 01 writes wdata[15:8], [7:0].
  - size 1x writes [31:24]..[7:0].
  - The ack response follows after 1 cycle with rsp_rdata=0 and rsp_error=0.
- Load: data is snapshotted from the array at the accept edge and held in the latency pipeline.
  - Byte: zero-extended when req_se=0; replicates bit 7 when req_se=1.
  - Half: zero-extended when req_se=0; replicates bit 15 when req_se=1.
  - Word: req_se is ignored.
- rsp_valid is never held; the consumer must sample it in the pulse cycle. There is no response backpressure.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, state IDLE, counter 0.
- Reset mid-operation (WAIT or RESP) discards the pending response. A store already accepted remains committed.
- Latencies, for a request accepted at edge k:
  - Load: rsp_valid is first high after edge k+READ_LATENCY, for exactly one cycle.
  - Store or error: rsp_valid is high after edge k+1.
- req_ready is 0 from edge k+1 through edge k+READ_LATENCY-1 for loads, and high again in the RESP cycle.
- Throughput:
  - READ_LATENCY=1 supports back-to-back accepts every cycle.
  - Otherwise a load occupies READ_LATENCY cycles.
- Ordering: a load accepted at edge k+1 after a store at edge k to the same bytes returns the stored value.
- rsp_rdata and rsp_error return to 0 in every cycle where rsp_valid=0.
- A request presented while req_ready=0 is ignored and must be held by the requester.

## Test plan
- **Word store, byte loads.** Reset, then store word 0x12345678 at 0x010. Then load bytes 0x010..0x013 with se=0. Required: rdata = 0x12, 0x34, 0x56, 0x78 respectively; store ack has rdata=0, error=0.
- **Sign extension.** Store half 0x80F0 at 0x020. Required: load half se=1 returns 0xFFFF80F0; se=0 returns 0x000080F0. Byte 0x021 with se=1 returns 0xFFFFFFF0.
- **Misalignment rejection.** With ALIGN_CHECK=1, store word 0xDEADBEEF at 0x031. Required: rsp_error=1 after 1 cycle, and a word load at 0x030 still returns its prior contents. Half load at 0x033 also gives rsp_error=1 and rdata=0.
- **Latency and handshake.** With READ_LATENCY=3 and req_valid held high continuously, issue loads back to back. Required: rsp_valid rises exactly 3 edges after each accept, req_ready is low for 2 cycles per load, and no request is lost or duplicated.
- **Reset mid-read.** With READ_LATENCY=4, assert reset 2 cycles after a load accept. Required: no rsp_valid pulse, req_ready=1 after reset, and memory contents preserved.
- **Wrap-around.** With ALIGN_CHECK=0 and ADDR_WIDTH=9, store word 0xA1B2C3D4 at 0x1FE. Required: Mem[0x1FE]=0xA1, Mem[0x1FF]=0xB2, Mem[0x000]=0xC3, Mem[0x001]=0xD4, and a word load at 0x1FE returns 0xA1B2C3D4.
